fpu_share_arbiter: RTL and testbench

Sequencer and two-port arbiter that shares the single-precision `coprocessor1` datapath between two requesters, e.g. the integer pipeline's COP1 issue and a future vector/load-convert unit. It accepts one operation at a time over a valid/ready handshake and drives `data1`/`data2`/`FloatALUop` on the shared FPU. It holds those operands stable for a programmable number of settle cycles, captures `floatRes`, and returns it to the winning requester with a one-cycle response strobe.

---
 rtl/fpu_share_arbiter.sv | 103 ++++++++++
 tb/tb_fpu_share_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fpu_share_arbiter.sv
// fpu_share_arbiter: shares one combinational coprocessor1 FPU between two valid/ready requesters
// Ports: clk, reset_n (async active-low); reqN_valid/reqN_ready/reqN_a/reqN_b/reqN_op request channel
// per requester; rspN_valid one-cycle response strobe qualifying the shared rsp_data;
// fpu_data1/fpu_data2/fpu_op drive the FPU and fpu_res returns its result; busy is high outside IDLE.
// LATENCY (1..15) sets how many cycles operands settle on the FPU before fpu_res is captured.
// Build option FPU_ROUND_ROBIN_EN: ties go to the requester not granted most recently
// (requester 0 first after reset); undefined gives fixed priority to requester 0.
module fpu_share_arbiter #(
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_data,
  output logic [31:0] fpu_data1,
  output logic [31:0] fpu_data2,
  output logic [2:0]  fpu_op,
  input  logic [31:0] fpu_res,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0]  op_q, op_d;
  logic        win, grant;
  // win is the ID of the requester that would be granted this cycle
`ifdef FPU_ROUND_ROBIN_EN
  logic last_q;
  assign win = (req0_valid && req1_valid) ? ~last_q : ~req0_valid;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) last_q <= 1'b1;
    else if (grant) last_q <= win;
`else
  assign win = ~req0_valid;
`endif
  assign grant      = state_q == IDLE && (req0_valid || req1_valid);
  // reset_n gating keeps both readies low while reset is asserted even if a valid is high
  assign req0_ready = reset_n && grant && !win;
  assign req1_ready = reset_n && grant && win;
  assign rsp0_valid = state_q == DONE && !owner_q;
  assign rsp1_valid = state_q == DONE && owner_q;
  assign rsp_data   = res_q;
  assign fpu_data1  = a_q;
  assign fpu_data2  = b_q;
  assign fpu_op     = op_q;
  assign busy       = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (grant) begin
        state_d = EXEC;
        cnt_d   = 4'(LATENCY - 1);
        owner_d = win;
        a_d     = win ? req1_a : req0_a;
        b_d     = win ? req1_b : req0_b;
        op_d    = win ? req1_op : req0_op;
      end
      EXEC: begin
        state_d = cnt_q == 4'd0 ? DONE : EXEC;
        cnt_d   = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
        res_d   = cnt_q == 4'd0 ? fpu_res : res_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      owner_q <= 1'b0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 3'd0;
      res_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
endmodule

// File: tb/tb_fpu_share_arbiter.sv
// tb_fpu_share_arbiter: directed self-checking bench for fpu_share_arbiter (LATENCY 2, 1 and 15)
module tb_fpu_share_arbiter;
  logic clk = 1'b0, reset_n = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0, req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0] req0_op = '0, req1_op = '0;
  logic rsp0_valid, rsp1_valid, busy;
  logic [31:0] rsp_data, fpu_data1, fpu_data2, fpu_res;
  logic [2:0] fpu_op;
  logic v_l1 = 1'b0, rdy_l1, rdy1_l1, rsp_l1, rsp1_l1, busy_l1;
  logic [31:0] d_l1, a_l1, b_l1, res_l1;
  logic [2:0] op_l1;
  logic v_l15 = 1'b0, rdy_l15, rdy1_l15, rsp_l15, rsp1_l15, busy_l15;
  logic [31:0] d_l15, a_l15, b_l15, res_l15;
  logic [2:0] op_l15;
  int n_chk = 0, n_pass = 0, w;
  bit sec;
  localparam logic [31:0] LA = 32'h40490fdb, LB = 32'h3f800000;
  localparam logic [2:0]  LOP = 3'd5;

  // stand-in for the combinational coprocessor1; exact for the documented 0.1 + 1.0 vector
  function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] o);
    return (x == 32'h3dcccccd && y == 32'h3f800000 && o == 3'd0) ? 32'h3f8ccccd
           : (x ^ {y[15:0], y[31:16]}) + {29'd0, o};
  endfunction

  assign fpu_res = model(fpu_data1, fpu_data2, fpu_op);
  assign res_l1  = model(a_l1, b_l1, op_l1);
  assign res_l15 = model(a_l15, b_l15, op_l15);

  always #5 clk = ~clk;

  fpu_share_arbiter #(.LATENCY(2)) dut (
    .clk, .reset_n, .req0_valid, .req0_ready, .req0_a, .req0_b, .req0_op,
    .req1_valid, .req1_ready, .req1_a, .req1_b, .req1_op, .rsp0_valid, .rsp1_valid,
    .rsp_data, .fpu_data1, .fpu_data2, .fpu_op, .fpu_res, .busy
  );
  fpu_share_arbiter #(.LATENCY(1)) dut_l1 (
    .clk(clk), .reset_n(reset_n), .req0_valid(v_l1), .req0_ready(rdy_l1), .req0_a(LA),
    .req0_b(LB), .req0_op(LOP), .req1_valid(1'b0), .req1_ready(rdy1_l1), .req1_a(32'd0),
    .req1_b(32'd0), .req1_op(3'd0), .rsp0_valid(rsp_l1), .rsp1_valid(rsp1_l1), .rsp_data(d_l1),
    .fpu_data1(a_l1), .fpu_data2(b_l1), .fpu_op(op_l1), .fpu_res(res_l1), .busy(busy_l1)
  );
  fpu_share_arbiter #(.LATENCY(15)) dut_l15 (
    .clk(clk), .reset_n(reset_n), .req0_valid(v_l15), .req0_ready(rdy_l15), .req0_a(LA),
    .req0_b(LB), .req0_op(LOP), .req1_valid(1'b0), .req1_ready(rdy1_l15), .req1_a(32'd0),
    .req1_b(32'd0), .req1_op(3'd0), .rsp0_valid(rsp_l15), .rsp1_valid(rsp1_l15), .rsp_data(d_l15),
    .fpu_data1(a_l15), .fpu_data2(b_l15), .fpu_op(op_l15), .fpu_res(res_l15), .busy(busy_l15)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // waits for whoN_ready, then follows the operation to its response strobe;
  // exp_n is the strobe cycle counted from the acceptance cycle, w the idle wait before acceptance
  task automatic serve(input bit who, input int exp_n, input bit raise1, output int wt);
    int n;
    bit ok;
    logic [31:0] a, b;
    logic [2:0] op;
    wt = 0;
    #1;
    while (!(who ? req1_ready : req0_ready) && wt < 40) begin
      step();
      #1;
      wt++;
    end
    check(who ? "grant1" : "grant0", who ? req1_ready : req0_ready, 1);
    check("grant_excl", who ? req0_ready : req1_ready, 0);
    a  = who ? req1_a : req0_a;
    b  = who ? req1_b : req0_b;
    op = who ? req1_op : req0_op;
    step();
    n  = 1;
    ok = 1;
    while (!(who ? rsp1_valid : rsp0_valid) && n < 40) begin
      if (raise1 && n == 2) req1_valid = 1'b1;
      ok &= busy && fpu_data1 == a && fpu_data2 == b && fpu_op == op
            && !req0_ready && !req1_ready && !rsp0_valid && !rsp1_valid;
      step();
      n++;
    end
    check("latency", n, exp_n);
    check("hold_exec", ok, 1);
    check("rsp_data", rsp_data, model(a, b, op));
    check("rsp_other", who ? rsp0_valid : rsp1_valid, 0);
    check("busy_done", busy, 1);
  endtask

  task automatic lat_test(input bit big, input int exp_n);
    int n;
    bit ok;
    if (big) v_l15 = 1'b1;
    else v_l1 = 1'b1;
    #1;
    check(big ? "ready_l15" : "ready_l1", big ? rdy_l15 : rdy_l1, 1);
    step();
    v_l1  = 1'b0;
    v_l15 = 1'b0;
    n  = 1;
    ok = 1;
    while (!(big ? rsp_l15 : rsp_l1) && n < 40) begin
      ok &= big ? (a_l15 == LA && b_l15 == LB && op_l15 == LOP && busy_l15)
                : (a_l1 == LA && b_l1 == LB && op_l1 == LOP && busy_l1);
      step();
      n++;
    end
    check(big ? "latency_l15" : "latency_l1", n, exp_n);
    check(big ? "hold_l15" : "hold_l1", ok, 1);
    check(big ? "data_l15" : "data_l1", big ? d_l15 : d_l1, model(LA, LB, LOP));
    step();
    check(big ? "idle_l15" : "idle_l1", big ? {busy_l15, rsp_l15} : {busy_l1, rsp_l1}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    #12;
    check("rst_ready", {req0_ready, req1_ready}, 0);
    check("rst_rsp", {rsp0_valid, rsp1_valid, busy}, 0);
    check("rst_data", rsp_data, 0);
    check("rst_fpu1", fpu_data1, 0);
    check("rst_fpu_op", fpu_op, 0);
    step();
    reset_n = 1'b1;
    step();
    // single op from requester 0
    req0_a = 32'h3dcccccd; req0_b = 32'h3f800000; req0_op = 3'd0; req0_valid = 1'b1;
    serve(0, 3, 0, w);
    check("single_wait", w, 0);
    check("single_rsp", rsp_data, 32'h3f8ccccd);
    req0_valid = 1'b0;
    step();
    check("single_idle", {busy, rsp0_valid, rsp1_valid}, 0);
    check("single_hold_rsp", rsp_data, 32'h3f8ccccd);
    // requester 1 arrives during EXEC
    req0_a = 32'h11112222; req0_b = 32'h40000000; req0_op = 3'd7; req0_valid = 1'b1;
    req1_a = 32'h33334444; req1_b = 32'h41200000; req1_op = 3'd3;
    serve(0, 3, 1, w);
    check("exec_op7", fpu_op, 3'd7);
    req0_valid = 1'b0;
    step();
    #1;
    check("late_ready1", req1_ready, 1);
    check("late_fpu1_hold", fpu_data1, 32'h11112222);
    serve(1, 3, 0, w);
    check("late_wait", w, 0);
    req1_valid = 1'b0;
    step();
    // both requesters valid across several services
    req0_a = 32'hc0a00000; req0_b = 32'h3e800000; req0_op = 3'd1; req0_valid = 1'b1;
    req1_a = 32'h42c80000; req1_b = 32'hbf000000; req1_op = 3'd2; req1_valid = 1'b1;
    serve(0, 3, 0, w);
    check("tie_first_wait", w, 0);
    req0_a = 32'h7f7fffff; req0_b = 32'h00800000; req0_op = 3'd6;
`ifdef FPU_ROUND_ROBIN_EN
    sec = 1'b1;
`else
    sec = 1'b0;
`endif
    serve(sec, 3, 0, w);
    check("tie_second_wait", w, 1);
    if (sec) req1_valid = 1'b0;
    else req0_valid = 1'b0;
    serve(!sec, 3, 0, w);
    check("tie_third_wait", w, 1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    // reset in the second EXEC cycle
    req0_a = 32'h0badf00d; req0_b = 32'h12345678; req0_op = 3'd4; req0_valid = 1'b1;
    #1;
    check("rst_test_ready", req0_ready, 1);
    step();
    req0_valid = 1'b0;
    step();
    check("rst_test_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("amid_busy", {busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready}, 0);
    check("amid_data", rsp_data, 0);
    check("amid_fpu1", fpu_data1, 0);
    check("amid_fpu2", fpu_data2, 0);
    check("amid_op", fpu_op, 0);
    step();
    step();
    reset_n = 1'b1;
    ok = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      ok &= !rsp0_valid && !rsp1_valid && !busy;
    end
    check("no_rsp_after_rst", ok, 1);
    req0_valid = 1'b1;
    serve(0, 3, 0, w);
    req0_valid = 1'b0;
    step();
    // extreme latencies
    lat_test(0, 2);
    lat_test(1, 16);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
